serial_rx_ctrl: RTL



---
 rtl/serial_rx_ctrl.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/serial_rx_ctrl.sv
// Receive sequencer for the byte-serial link: start detection, centre-sampled
// LSB-first assembly, stop check and a one-entry valid/ready holding register.
module serial_rx_ctrl #(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_BITS    = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx_in,
    input  logic                 rx_en,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 data_valid,
    input  logic                 data_ready,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 busy
);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_HIGH
    } state_t;

    localparam logic [7:0] CNT_LAST = 8'(CLKS_PER_BIT - 1);
    localparam logic [7:0] CNT_MID  = 8'(CLKS_PER_BIT / 2 - 1);
    localparam logic [3:0] IDX_LAST = 4'(DATA_BITS - 1);

    state_t               state_reg, state_next;
    logic [1:0]           sync_reg;
    logic                 rxs;
    logic [7:0]           cnt_reg, cnt_next;
    logic [3:0]           bit_idx_reg, bit_idx_next;
    logic [DATA_BITS-1:0] shift_reg, shift_next;
    logic [DATA_BITS-1:0] data_out_reg, data_out_next;
    logic                 data_valid_reg, data_valid_next;
    logic                 frame_err_reg, frame_err_next;
    logic                 overrun_reg, overrun_next;

    // Line idles high, so the synchroniser resets to 1 to avoid a false start.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_reg <= 2'b11;
        end else begin
            sync_reg <= {sync_reg[0], rx_in};
        end
    end

    assign rxs = sync_reg[1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= IDLE;
            cnt_reg        <= '0;
            bit_idx_reg    <= '0;
            shift_reg      <= '0;
            data_out_reg   <= '0;
            data_valid_reg <= 1'b0;
            frame_err_reg  <= 1'b0;
            overrun_reg    <= 1'b0;
        end else begin
            state_reg      <= state_next;
            cnt_reg        <= cnt_next;
            bit_idx_reg    <= bit_idx_next;
            shift_reg      <= shift_next;
            data_out_reg   <= data_out_next;
            data_valid_reg <= data_valid_next;
            frame_err_reg  <= frame_err_next;
            overrun_reg    <= overrun_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        cnt_next        = cnt_reg + 8'd1;
        bit_idx_next    = bit_idx_reg;
        shift_next      = shift_reg;
        data_out_next   = data_out_reg;
        data_valid_next = data_valid_reg;
        frame_err_next  = 1'b0;
        overrun_next    = 1'b0;

        if (data_valid_reg && data_ready) begin
            data_valid_next = 1'b0;
        end

        case (state_reg)
            IDLE: begin
                cnt_next = '0;
                if (rx_en && !rxs) begin
                    state_next = START;
                end
            end
            START: begin
                if (cnt_reg == CNT_MID) begin
                    cnt_next = '0;
                    if (!rxs) begin
                        state_next   = DATA;
                        bit_idx_next = '0;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            DATA: begin
                if (cnt_reg == CNT_LAST) begin
                    cnt_next     = '0;
                    shift_next   = {rxs, shift_reg[DATA_BITS-1:1]};
                    bit_idx_next = bit_idx_reg + 4'd1;
                    if (bit_idx_reg == IDX_LAST) begin
                        state_next = STOP;
                    end
                end
            end
            STOP: begin
                if (cnt_reg == CNT_LAST) begin
                    cnt_next = '0;
                    if (rxs) begin
                        state_next = IDLE;
                        // A same-cycle handshake frees the holding register for the new byte.
                        if (!data_valid_reg || data_ready) begin
                            data_out_next   = shift_reg;
                            data_valid_next = 1'b1;
                        end else begin
                            overrun_next = 1'b1;
                        end
                    end else begin
                        state_next     = WAIT_HIGH;
                        frame_err_next = 1'b1;
                    end
                end
            end
            WAIT_HIGH: begin
                cnt_next = '0;
                if (rxs) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    assign data_out   = data_out_reg;
    assign data_valid = data_valid_reg;
    assign frame_err  = frame_err_reg;
    assign overrun    = overrun_reg;
    assign busy       = (state_reg != IDLE);

endmodule
